// File: rtl/arbitro_enrutamiento_wrr.sv
// arbitro_enrutamiento_wrr: weighted round-robin VC arbiter that routes popped heads into destination FIFOs
// Define ARB_GLOBAL_PAUSE_EN to stall every grant whenever any destination is paused.
module arbitro_enrutamiento_wrr #(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 2,
  parameter int NUM_DEST = 2,
  parameter int WEIGHT_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC*DATA_W-1:0]    vc_data,
  input  logic [NUM_VC-1:0]           vc_empty,
  input  logic [NUM_VC*WEIGHT_W-1:0]  vc_weight,
  input  logic [NUM_DEST-1:0]         dest_pause,
  output logic [NUM_VC-1:0]           vc_pop,
  output logic [NUM_DEST*DATA_W-1:0]  dest_data,
  output logic [NUM_DEST-1:0]         dest_push,
  output logic                        idle
);
  localparam int SEL_W = $clog2(NUM_DEST);
  localparam int PTR_W = $clog2(NUM_VC);
  logic [PTR_W-1:0] ptr, g, ix, ptr_next;
  logic [WEIGHT_W-1:0] credit, w_g, cur, rem;
  logic [SEL_W-1:0] route [NUM_VC];
  logic [SEL_W-1:0] route_g;
  logic [DATA_W-1:0] data_g;
  logic [NUM_VC-1:0] elig;
  logic found;
  int idx;
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      route[i] = vc_data[i*DATA_W+DATA_W-1 -: SEL_W];
      if ({1'b0, route[i]} >= (SEL_W+1)'(NUM_DEST)) route[i] = SEL_W'(NUM_DEST-1);
`ifdef ARB_GLOBAL_PAUSE_EN
      elig[i] = !vc_empty[i] && !dest_pause[route[i]] && !(|dest_pause);
`else
      elig[i] = !vc_empty[i] && !dest_pause[route[i]];
`endif
    end
    found = 1'b0;
    g = '0;
    idx = 0;
    ix = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      ix = PTR_W'(idx);
      if (!found && elig[ix]) begin
        found = 1'b1;
        g = ix;
      end
    end
    data_g = '0;
    route_g = '0;
    w_g = '0;
    for (int i = 0; i < NUM_VC; i++)
      if (g == PTR_W'(i)) begin
        data_g = vc_data[i*DATA_W +: DATA_W];
        route_g = route[i];
        w_g = vc_weight[i*WEIGHT_W +: WEIGHT_W];
      end
    // a credit only survives while the grant stays on ptr; any skip starts a fresh turn
    cur = (g == ptr && credit != '0) ? credit : (w_g == '0 ? WEIGHT_W'(1) : w_g);
    rem = cur - WEIGHT_W'(1);
    ptr_next = rem != '0 ? g : (g == PTR_W'(NUM_VC-1) ? '0 : g + PTR_W'(1));
  end
  assign vc_pop = (found && !reset) ? NUM_VC'(1) << g : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      credit <= '0;
      dest_push <= '0;
      dest_data <= '0;
      idle <= 1'b1;
    end else begin
      if (found) begin
        ptr <= ptr_next;
        credit <= rem;
      end
      idle <= &vc_empty && !(|dest_push);
      for (int d = 0; d < NUM_DEST; d++) begin
        dest_push[d] <= found && route_g == SEL_W'(d);
        if (found && route_g == SEL_W'(d)) dest_data[d*DATA_W +: DATA_W] <= data_g;
      end
    end
endmodule

// File: doc/arbitro_enrutamiento_wrr.md
# arbitro_enrutamiento_wrr

Parametrised successor to the two-channel arbiter/router of the PCIe transmit layer. It takes NUM_VC virtual-channel FIFO heads, selects at most one per cycle with weighted round-robin, pops it, and pushes the word into one of NUM_DEST destination FIFOs chosen by a route field in the word. Per-destination back-pressure replaces the all-or-nothing pause. Output is registered.

## Interface
- DATA_W, 6, word width
- NUM_VC, 2, virtual-channel inputs (≥2)
- NUM_DEST, 2, destinations (≥2)
- WEIGHT_W, 3, width of each per-VC weight
- SEL_W, derived clog2(NUM_DEST), route field width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- vc_data  in  NUM_VC*DATA_W  show-ahead FIFO heads, VC i at [i*DATA_W +: DATA_W]
- vc_empty  in  NUM_VC  head invalid when 1
- vc_weight  in  NUM_VC*WEIGHT_W  grants per turn for each VC; 0 is treated as 1
- dest_pause  in  NUM_DEST  destination almost-full
- vc_pop  out  NUM_VC  combinational one-hot-or-zero pop
- dest_data  out  NUM_DEST*DATA_W  registered words
- dest_push  out  NUM_DEST  registered one-hot-or-zero push
- idle  out  1  registered: all vc_empty and no push in the previous cycle

## Operation
- Route of VC i: r = vc_data[i][DATA_W-1 -: SEL_W]; r ≥ NUM_DEST clamps to NUM_DEST-1.
- eligible[i] = !vc_empty[i] && !dest_pause[r_i].
- State: ptr (clog2(NUM_VC) bits) and credit (WEIGHT_W bits). credit==0 means the VC at ptr starts a fresh turn.
- Grant g = first eligible index searching ptr, ptr+1, … with wrap. With no eligible VC there is no grant and the state holds.
- On a grant:
  - vc_pop[g]=1 in the same cycle.
  - cur = (g==ptr && credit!=0) ? credit : max(vc_weight[g],1); rem = cur-1.
  - If rem==0: ptr ← (g+1) mod NUM_VC and credit ← 0. Otherwise ptr ← g and credit ← rem.
- A skipped (ineligible) ptr loses its remaining credit.
- Next edge after a grant: dest_push[r_g] ← 1, dest_data[r_g] ← vc_data[g], and all other dest_push ← 0. The dest_data of non-pushed destinations holds its value.
- Weights are sampled at use. Changing them mid-turn affects only fresh turns.

## Timing
- Reset (async): ptr=0, credit=0, dest_push=0, dest_data=0, idle=1. vc_pop=0 while reset is high.
- Latency: pop in cycle N, push in cycle N+1. Throughput is one word per cycle.
- dest_pause is evaluated combinationally in the grant cycle. The destination must absorb the one push that may already be in flight when pause rises.
- vc_empty and vc_pop are in the same cycle, so popping an empty VC is impossible.
- If reset is asserted while a push is registered, dest_push drops immediately. The popped word is lost, which is acceptable because the FIFOs reset too.

## Configuration
- ARB_GLOBAL_PAUSE_EN defined: eligible[i] also requires that no dest_pause bit is set. Any paused destination stalls all grants, which is the legacy behaviour.
- Undefined (default): only VCs whose routed destination is paused are blocked. Others continue.

## Test plan
- Reset mid-traffic: reset=1 while dest_push=2'b01 → dest_push=0, dest_data=0, and idle=1 without waiting for a clock; first grant after release is VC0.
- Weights {VC1=1, VC0=3}, both VCs non-empty, all words routed to dest0, no pause → vc_pop sequence 01,01,01,10,01,01,01,10.
- Weights 0,0, both non-empty → strict alternation 01,10,01,10.
- Macro off: VC0 head 6'h25 (route 1) with dest_pause=2'b10, VC1 head 6'h05 (route 0) → only vc_pop=2'b10; next cycle dest_push=2'b01, dest_data[0]=6'h05.
- Macro on, same stimulus → vc_pop=0 and dest_push=0 every cycle until dest_pause=0.
- Only VC1 non-empty, head 6'h25, weight 1 → vc_pop=2'b10 every cycle; dest_push=2'b10 and dest_data[1]=6'h25 one cycle later.
